// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with pending/enable/edge/active
// registers, a req/ack handshake toward the core and a nesting stack of
// saved PC/ID pairs for preemption and RETIRQ.
module irq_ctrl #(
  parameter int unsigned NIRQ       = 8,
  parameter int unsigned NEST       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 4,
  localparam int unsigned IDW       = $clog2(NIRQ),
  localparam int unsigned DW        = $clog2(NEST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] sw_set,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [NIRQ-1:0] cfg_wdata,
  output logic [NIRQ-1:0] cfg_rdata,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  output logic [31:0]     irq_vec,
  input  logic            irq_ack,
  input  logic [31:0]     pc,
  input  logic            irq_ret,
  output logic [31:0]     pc_ret,
  output logic [DW-1:0]   depth,
  output logic            ret_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic            irq_req_q;
  logic [IDW-1:0]  irq_id_q;

  logic [NIRQ-1:0] enable_q;
  logic [NIRQ-1:0] edge_q;
  logic [NIRQ-1:0] pend_q;
  logic [NIRQ-1:0] active_q;
  logic [NIRQ-1:0] prev_q;
  logic [NIRQ-1:0] pend_d;
  logic [NIRQ-1:0] active_d;
  logic [NIRQ-1:0] set_vec;
  logic [NIRQ-1:0] clr_vec;

  logic [31:0]     stk_pc_q [NEST];
  logic [IDW-1:0]  stk_id_q [NEST];
  logic [DW-1:0]   depth_q;
  logic [DW-1:0]   depth_pop;
  logic [DW-1:0]   depth_d;
  logic            ret_err_q;

  logic            accept;
  logic            pop;
  logic [31:0]     top_pc;
  logic [IDW-1:0]  top_id;
  logic [NIRQ-1:0] elig;
  logic            cand_vld;
  logic [IDW-1:0]  cand_id;
  logic            permit;

  assign accept = (state_q == S_REQ) && irq_ack;
  assign pop    = irq_ret && (depth_q != '0);

  // Top-of-stack view; reads as zero when the stack is empty.
  always_comb begin
    top_pc = '0;
    top_id = '0;
    for (int unsigned i = 0; i < NEST; i++) begin
      if (32'(depth_q) == i + 1) begin
        top_pc = stk_pc_q[i];
        top_id = stk_id_q[i];
      end
    end
  end

  // Depth after a RETIRQ pop, then after an accept push (pop happens first).
  always_comb begin
    depth_pop = pop ? depth_q - DW'(1) : depth_q;
    depth_d   = accept ? depth_pop + DW'(1) : depth_pop;
  end

  // Lowest-index eligible source and whether it may preempt the current handler.
  always_comb begin
    elig     = pend_q & enable_q & ~active_q;
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (elig[i] && !cand_vld) begin
        cand_vld = 1'b1;
        cand_id  = IDW'(i);
      end
    end
    permit = cand_vld &&
             ((depth_q == '0) || ((32'(depth_q) < NEST) && (cand_id < top_id)));
  end

  // Pending set/clear sources; any set overrides a clear on the same bit.
  always_comb begin
    set_vec = sw_set | (irq_in & ~(edge_q & prev_q));
    clr_vec = '0;
    if (cfg_we && (cfg_addr == 2'd2)) begin
      clr_vec = cfg_wdata;
    end
    if (accept) begin
      clr_vec[irq_id_q] = 1'b1;
    end
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // ACTIVE update: the popped handler retires before the accepted one starts.
  always_comb begin
    active_d = active_q;
    if (pop) begin
      active_d[top_id] = 1'b0;
    end
    if (accept) begin
      active_d[irq_id_q] = 1'b1;
    end
  end

  // Configuration read mux.
  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = enable_q;
      2'd1:    cfg_rdata = edge_q;
      2'd2:    cfg_rdata = pend_q;
      default: cfg_rdata = active_q;
    endcase
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign irq_vec = VEC_BASE + 32'(irq_id_q) * VEC_STRIDE;
  assign pc_ret  = top_pc;
  assign depth   = depth_q;
  assign ret_err = ret_err_q;

  // Request handshake FSM: capture a permitted candidate, hold it until accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (permit) begin
            state_q   <= S_REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= cand_id;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            state_q   <= S_HOLD;
            irq_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Configuration, pending, active and edge-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      active_q <= '0;
      prev_q   <= '0;
    end else begin
      if (cfg_we && (cfg_addr == 2'd0)) begin
        enable_q <= cfg_wdata;
      end
      if (cfg_we && (cfg_addr == 2'd1)) begin
        edge_q <= cfg_wdata;
      end
      pend_q   <= pend_d;
      active_q <= active_d;
      prev_q   <= irq_in;
    end
  end

  // Nesting stack: a push writes the slot just above the post-pop depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < NEST; i++) begin
        stk_pc_q[i] <= '0;
        stk_id_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      for (int unsigned i = 0; i < NEST; i++) begin
        if (accept && (32'(depth_pop) == i)) begin
          stk_pc_q[i] <= pc;
          stk_id_q[i] <= irq_id_q;
        end
      end
    end
  end

  // One-cycle error pulse for RETIRQ with nothing to return from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_err_q <= 1'b0;
    end else begin
      ret_err_q <= irq_ret && (depth_q == '0);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios plus a randomized run, all
// compared every cycle against a queue-based reference model.
module tb_irq_ctrl;

  localparam int unsigned NIRQ = 8;
  localparam int unsigned NEST = 2;
  localparam logic [31:0] VB   = 32'h0000_0100;
  localparam int unsigned VS   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in, sw_set, cfg_wdata, cfg_rdata;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [31:0] irq_vec, pc, pc_ret;
  logic        irq_ack, irq_ret;
  logic [1:0]  depth;
  logic        ret_err;

  always #5 clk = ~clk;

  irq_ctrl #(.NIRQ(NIRQ), .NEST(NEST), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sw_set(sw_set),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_req(irq_req), .irq_id(irq_id), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .pc(pc), .irq_ret(irq_ret), .pc_ret(pc_ret), .depth(depth), .ret_err(ret_err)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    int unsigned id;
  } ent_t;

  logic [7:0]  m_en, m_edge, m_pend, m_act, m_prev;
  ent_t        m_stk[$];
  bit          m_req, m_hold, m_err;
  int unsigned m_id;

  function automatic void model_reset();
    m_en = '0; m_edge = '0; m_pend = '0; m_act = '0; m_prev = '0;
    m_stk.delete();
    m_req = 0; m_hold = 0; m_err = 0; m_id = 0;
  endfunction

  function automatic void model_step();
    bit          found, perm, acc;
    int unsigned cand;
    logic [7:0]  setv, clrv;
    ent_t        e;
    if (rst) begin
      model_reset();
      return;
    end
    found = 0;
    cand  = 0;
    for (int i = 0; i < NIRQ; i++)
      if (!found && m_pend[i] && m_en[i] && !m_act[i]) begin
        found = 1;
        cand  = i;
      end
    perm = found && (m_stk.size() == 0 ||
                     (m_stk.size() < NEST && cand < m_stk[$].id));
    acc  = m_req && irq_ack;
    setv = '0;
    for (int i = 0; i < NIRQ; i++)
      if (sw_set[i] || (irq_in[i] && (!m_edge[i] || !m_prev[i]))) setv[i] = 1'b1;
    clrv = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 8'h00;
    if (acc) clrv[m_id] = 1'b1;
    m_err = irq_ret && m_stk.size() == 0;
    if (irq_ret && m_stk.size() > 0) begin
      m_act[m_stk[$].id] = 1'b0;
      void'(m_stk.pop_back());
    end
    if (acc) begin
      e.pc = pc;
      e.id = m_id;
      m_stk.push_back(e);
      m_act[m_id] = 1'b1;
    end
    m_pend = (m_pend & ~clrv) | setv;
    if (cfg_we && cfg_addr == 2'd0) m_en = cfg_wdata;
    if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata;
    m_prev = irq_in;
    if (m_req) begin
      if (irq_ack) begin
        m_req  = 0;
        m_hold = 1;
      end
    end else if (m_hold) begin
      m_hold = 0;
    end else if (perm) begin
      m_req = 1;
      m_id  = cand;
    end
  endfunction

  task automatic compare_all();
    logic [31:0] epc;
    logic [7:0]  erd;
    epc = 32'h0;
    if (m_stk.size() > 0) epc = m_stk[$].pc;
    case (cfg_addr)
      2'd0:    erd = m_en;
      2'd1:    erd = m_edge;
      2'd2:    erd = m_pend;
      default: erd = m_act;
    endcase
    check("m_req", irq_req, m_req);
    check("m_id", irq_id, m_id);
    check("m_vec", irq_vec, VB + m_id * VS);
    check("m_depth", depth, m_stk.size());
    check("m_pc_ret", pc_ret, epc);
    check("m_ret_err", ret_err, m_err);
    check("m_rdata", cfg_rdata, erd);
  endtask

  // Inputs are driven after negedge; compare, step through posedge, return at negedge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0; cfg_wdata = '0;
  endtask

  task automatic raise(input int unsigned i);
    irq_in = 8'h00;
    irq_in[i] = 1'b1;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic wait_req(input int unsigned max);
    int unsigned n = 0;
    while (!irq_req && n < max) begin
      tick();
      n++;
    end
    check("req_timeout", irq_req, 1);
  endtask

  task automatic take(input logic [31:0] p);
    wait_req(10);
    irq_ack = 1; pc = p;
    tick();
    irq_ack = 0;
  endtask

  task automatic ret_chk(input string tag, input logic [31:0] exp_pc);
    irq_ret = 1;
    #1;
    check(tag, pc_ret, exp_pc);
    tick();
    irq_ret = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  initial begin
    rst = 1; irq_in = 0; sw_set = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    irq_ack = 0; pc = 0; irq_ret = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_req", irq_req, 0);
    check("rst_vec", irq_vec, VB);
    check("rst_depth", depth, 0);
    rst = 0;
    tick();

    // Basic
    cfg_wr(2'd0, 8'hFF);
    cfg_wr(2'd1, 8'hFF);
    raise(3);
    tick();
    check("basic_req", irq_req, 1);
    check("basic_id", irq_id, 3);
    check("basic_vec", irq_vec, 32'h10C);
    take(32'h40);
    check("basic_depth", depth, 1);
    rd_chk("basic_active", 2'd3, 8'h08);
    ret_chk("basic_pc_ret", 32'h40);
    check("basic_depth0", depth, 0);
    rd_chk("basic_active0", 2'd3, 8'h00);

    // Priority and hold
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    tick();
    check("pri_id", irq_id, 2);
    raise(0);
    tick();
    tick();
    check("pri_hold_req", irq_req, 1);
    check("pri_hold_id", irq_id, 2);
    take(32'h200);
    wait_req(10);
    check("pri_preempt_id", irq_id, 0);
    take(32'h300);
    check("pri_depth2", depth, 2);
    repeat (4) tick();
    check("pri_wait5", irq_req, 0);
    ret_chk("pri_ret0", 32'h300);
    repeat (3) tick();
    check("pri_still_wait5", irq_req, 0);
    ret_chk("pri_ret2", 32'h200);
    wait_req(10);
    check("pri_id5", irq_id, 5);
    take(32'h600);
    ret_chk("pri_ret5", 32'h600);

    // Nest limit
    raise(4);
    take(32'h44);
    raise(1);
    take(32'h11);
    raise(0);
    repeat (5) tick();
    check("nest_block", irq_req, 0);
    ret_chk("nest_ret1", 32'h11);
    wait_req(10);
    check("nest_id0", irq_id, 0);
    take(32'h99);
    ret_chk("nest_ret0", 32'h99);
    ret_chk("nest_ret4", 32'h44);

    // Level versus edge
    cfg_wr(2'd1, 8'hBF);
    irq_in = 8'h40;
    wait_req(10);
    check("lvl_id", irq_id, 6);
    take(32'h66);
    repeat (3) tick();
    rd_chk("lvl_repend", 2'd2, 8'h40);
    check("lvl_no_req", irq_req, 0);
    ret_chk("lvl_ret", 32'h66);
    wait_req(10);
    check("lvl_again", irq_id, 6);
    irq_in = 8'h00;
    take(32'h67);
    ret_chk("lvl_ret2", 32'h67);
    cfg_wr(2'd1, 8'hFF);
    irq_in = 8'h40;
    take(32'h70);
    ret_chk("edge_ret", 32'h70);
    repeat (6) tick();
    check("edge_once", irq_req, 0);
    irq_in = 8'h00;

    // Corner events
    irq_ret = 1;
    tick();
    irq_ret = 0;
    check("err_pulse", ret_err, 1);
    check("err_depth", depth, 0);
    tick();
    check("err_gone", ret_err, 0);
    raise(3);
    take(32'h30);
    raise(1);
    wait_req(10);
    check("swap_id", irq_id, 1);
    irq_ack = 1; irq_ret = 1; pc = 32'h500;
    tick();
    irq_ack = 0; irq_ret = 0;
    check("swap_depth", depth, 1);
    check("swap_pc", pc_ret, 32'h500);
    rd_chk("swap_active", 2'd3, 8'h02);
    ret_chk("swap_ret", 32'h500);
    cfg_wr(2'd0, 8'h00);
    sw_set = 8'h80; cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 8'h80;
    tick();
    sw_set = 0; cfg_we = 0;
    rd_chk("w1c_setwins", 2'd2, 8'h80);
    cfg_wr(2'd2, 8'hFF);

    // Reset during REQ with depth 1
    cfg_wr(2'd0, 8'hFF);
    raise(4);
    take(32'h44);
    raise(2);
    wait_req(10);
    #2;
    rst = 1;
    #1;
    check("arst_req", irq_req, 0);
    check("arst_id", irq_id, 0);
    check("arst_vec", irq_vec, VB);
    check("arst_depth", depth, 0);
    check("arst_pc_ret", pc_ret, 0);
    check("arst_err", ret_err, 0);
    model_reset();
    tick();
    rst = 0;
    repeat (4) tick();
    check("arst_quiet", irq_req, 0);

    // Randomized run
    cfg_wr(2'd0, 8'hFF);
    cfg_wr(2'd1, 8'($urandom));
    for (int n = 0; n < 3000; n++) begin
      irq_in    = 8'($urandom & $urandom & $urandom);
      sw_set    = ($urandom_range(0, 15) == 0) ? 8'($urandom & $urandom) : 8'h00;
      irq_ack   = 1'($urandom_range(0, 1));
      pc        = $urandom;
      irq_ret   = ($urandom_range(0, 7) == 0);
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 8'($urandom | $urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        #1;
        model_reset();
        compare_all();
        rst = 0;
      end
      tick();
    end
    irq_in = 0; sw_set = 0; irq_ack = 0; irq_ret = 0; cfg_we = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
